// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU timer states and
// parameter defaults.
package hazard_pkg;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_LAT_DEF = 32;
    localparam int unsigned BREG_DEF    = 5;
    localparam int unsigned BCNT_DEF    = 16;

endpackage

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
// Multiply/divide busy timer: holds the MDU in flight for MDU_LAT-1 cycles
// after a start is accepted. Only compiled when MDU_STALL_EN is defined.
`ifdef MDU_STALL_EN
module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam int unsigned bMCNT = $clog2(MDU_LAT);

    mdu_state_e       state_q, state_d;
    logic [bMCNT-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = bMCNT'(MDU_LAT - 1);
                end
            end
            MDU_BUSY: begin
                // Leave on the edge that takes the count to zero, so busy
                // spans exactly MDU_LAT-1 cycles.
                cnt_d = cnt_q - bMCNT'(1);
                if (cnt_q <= bMCNT'(1)) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == MDU_BUSY);

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and, when
// MDU_STALL_EN is defined, multiply/divide busy stalls; counts stall cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned bREG    = BREG_DEF,
    parameter int unsigned MDU_LAT = MDU_LAT_DEF,
    parameter int unsigned bCNT    = BCNT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [bREG-1:0] idRs,
    input  logic [bREG-1:0] idRt,
    input  logic            exMemRead,
    input  logic [bREG-1:0] exRt,
    input  logic            brTaken,
    input  logic            mduStart,
    input  logic            hiloRead,
    output logic            enWritePC,
    output logic            enWriteIFID,
    output logic            flushIFID,
    output logic            flushIDEX,
    output logic            mduBusy,
    output logic [bCNT-1:0] stallCount
);

    logic            lu;
    logic            mh;
    logic            stall;
    logic            mdu_busy;
    logic [bCNT-1:0] stall_count_q, stall_count_d;

`ifdef MDU_STALL_EN
    logic mdu_accept;

    assign mdu_accept = mduStart && !stall && !brTaken;
    assign mh         = mdu_busy && (mduStart || hiloRead);

    mdu_busy_timer #(
        .MDU_LAT(MDU_LAT)
    ) u_mdu_timer (
        .clock(clock),
        .reset(reset),
        .start(mdu_accept),
        .busy (mdu_busy)
    );
`else
    logic unused_mdu;

    assign unused_mdu = ^{mduStart, hiloRead, 8'(MDU_LAT)};
    assign mh         = 1'b0;
    assign mdu_busy   = 1'b0;
`endif

    always_comb begin
        lu          = exMemRead && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));
        stall       = (lu || mh) && !brTaken;
        enWritePC   = !stall;
        enWriteIFID = !stall;
        flushIFID   = brTaken;
        flushIDEX   = stall || brTaken;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + bCNT'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign mduBusy    = mdu_busy;
    assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: behavioural reference model checked every
// cycle, plus directed literal checks. MDU tests run when MDU_STALL_EN is defined.
module tb_hazard_ctrl;

    localparam int unsigned BREG = 5;
    localparam int unsigned LAT  = 4;
    localparam int unsigned BCNT = 4;
    localparam int          CMAX = (1 << BCNT) - 1;

    logic            clock;
    logic            reset;
    logic [BREG-1:0] idRs, idRt, exRt;
    logic            exMemRead, brTaken, mduStart, hiloRead;
    logic            enWritePC, enWriteIFID, flushIFID, flushIDEX, mduBusy;
    logic [BCNT-1:0] stallCount;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl #(
        .bREG   (BREG),
        .MDU_LAT(LAT),
        .bCNT   (BCNT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .idRs       (idRs),
        .idRt       (idRt),
        .exMemRead  (exMemRead),
        .exRt       (exRt),
        .brTaken    (brTaken),
        .mduStart   (mduStart),
        .hiloRead   (hiloRead),
        .enWritePC  (enWritePC),
        .enWriteIFID(enWriteIFID),
        .flushIFID  (flushIFID),
        .flushIDEX  (flushIDEX),
        .mduBusy    (mduBusy),
        .stallCount (stallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles and total stall cycles seen.
    int busy_left   = 0;
    int stall_total = 0;

    function automatic bit mdl_stall();
        bit lu, mh;
        lu = exMemRead && (exRt != 0) && ((exRt == idRs) || (exRt == idRt));
        mh = (busy_left > 0) && (mduStart || hiloRead);
        return (lu || mh) && !brTaken;
    endfunction

    always @(posedge clock or negedge reset) begin
        bit st;
        if (!reset) begin
            busy_left   = 0;
            stall_total = 0;
        end else begin
            st = mdl_stall();
            if (st) stall_total++;
            if (busy_left > 0) busy_left--;
`ifdef MDU_STALL_EN
            else if (mduStart && !st && !brTaken) busy_left = LAT - 1;
`endif
        end
    end

    always @(negedge clock) begin
        bit st;
        st = mdl_stall();
        chk("m_enWritePC",   int'(enWritePC),   int'(!st));
        chk("m_enWriteIFID", int'(enWriteIFID), int'(!st));
        chk("m_flushIFID",   int'(flushIFID),   int'(brTaken));
        chk("m_flushIDEX",   int'(flushIDEX),   int'(st || brTaken));
        chk("m_mduBusy",     int'(mduBusy),     int'(busy_left > 0));
        chk("m_stallCount",  int'(stallCount),  (stall_total > CMAX) ? CMAX : stall_total);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic idle_in();
        idRs = '0; idRt = '0; exRt = '0;
        exMemRead = 1'b0; brTaken = 1'b0; mduStart = 1'b0; hiloRead = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle_in();
        mid();
        chk("rst_stallCount", int'(stallCount), 0);
        chk("rst_mduBusy",    int'(mduBusy),    0);
        chk("rst_enWritePC",  int'(enWritePC),  1);
        step();
        step();
        reset = 1'b1;
        step();

        // Load-use on rs
        exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; idRt = 5'd3;
        mid();
        chk("lu_enWritePC",   int'(enWritePC),   0);
        chk("lu_enWriteIFID", int'(enWriteIFID), 0);
        chk("lu_flushIDEX",   int'(flushIDEX),   1);
        chk("lu_flushIFID",   int'(flushIFID),   0);
        chk("lu_cnt_before",  int'(stallCount),  0);
        step();
        idle_in();
        mid();
        chk("lu_cnt_after",   int'(stallCount),  1);
        chk("lu_release",     int'(enWritePC),   1);

        // Register zero never hazards
        exMemRead = 1'b1; exRt = '0; idRs = '0; idRt = '0;
        mid();
        chk("r0_enWritePC", int'(enWritePC), 1);
        chk("r0_flushIDEX", int'(flushIDEX), 0);
        chk("r0_flushIFID", int'(flushIFID), 0);
        step();

        // Branch overrides load-use
        exMemRead = 1'b1; exRt = 5'd8; idRt = 5'd8; brTaken = 1'b1;
        mid();
        chk("br_flushIFID",   int'(flushIFID),   1);
        chk("br_flushIDEX",   int'(flushIDEX),   1);
        chk("br_enWritePC",   int'(enWritePC),   1);
        chk("br_enWriteIFID", int'(enWriteIFID), 1);
        step();
        idle_in();
        mid();
        chk("br_cnt_same", int'(stallCount), 1);

`ifdef MDU_STALL_EN
        // MDU busy window and hi/lo stalls
        mduStart = 1'b1;
        step();
        mduStart = 1'b0;
        hiloRead = 1'b1;
        mid();
        chk("mdu_busy_e0", int'(mduBusy),   1);
        chk("mdu_stall_e0", int'(enWritePC), 0);
        step();
        mid();
        chk("mdu_busy_e1", int'(mduBusy), 1);
        step();
        mid();
        chk("mdu_busy_e2", int'(mduBusy), 1);
        step();
        mid();
        chk("mdu_busy_e3",  int'(mduBusy),    0);
        chk("mdu_free_e3",  int'(enWritePC),  1);
        chk("mdu_cnt",      int'(stallCount), 4);
        idle_in();
        step();

        // Async reset mid-BUSY abandons the operation
        mduStart = 1'b1;
        step();
        mduStart = 1'b0;
        mid();
        chk("ar_busy_before", int'(mduBusy), 1);
        reset = 1'b0;
        #1;
        chk("ar_busy_drop", int'(mduBusy), 0);
        #1;
        reset = 1'b1;
        hiloRead = 1'b1;
        mid();
        chk("ar_no_stall", int'(enWritePC), 1);
        chk("ar_busy_idle", int'(mduBusy),  0);
        idle_in();
        step();
`else
        // MDU inputs are ignored
        mduStart = 1'b1; hiloRead = 1'b1;
        step();
        mid();
        chk("nomdu_busy",  int'(mduBusy),   0);
        chk("nomdu_stall", int'(enWritePC), 1);
        idle_in();
        step();
`endif

        // Saturation of the stall counter
        pulse_reset();
        exMemRead = 1'b1; exRt = 5'd4; idRt = 5'd4;
        for (int i = 0; i < 20; i++) step();
        mid();
        chk("sat_cnt", int'(stallCount), 15);
        idle_in();
        step();

        // Randomised traffic with periodic reset
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) pulse_reset();
            idRs      = BREG'($urandom_range(0, 3));
            idRt      = BREG'($urandom_range(0, 3));
            exRt      = BREG'($urandom_range(0, 3));
            exMemRead = ($urandom_range(0, 1) == 1);
            brTaken   = ($urandom_range(0, 7) == 0);
            mduStart  = ($urandom_range(0, 5) == 0);
            hiloRead  = ($urandom_range(0, 4) == 0);
            step();
        end
        idle_in();
        step();
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
